// File: rtl/obs_wave_scheduler.sv
// Obstacle spawn scheduler: owns the obstacle slot pool, paces spawns per frame,
// releases slots on hit/bottom events and advances the level after each wave.
module obs_wave_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int MAX_X      = 640,
  parameter int OBS_SIZE   = 30,
  parameter int SPAWN_BASE = 60,
  parameter int SPAWN_STEP = 8,
  parameter int WAVE_LEN   = 10,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 refr_tick,
  input  logic                 game_run,
  input  logic                 new_game,
  input  logic [9:0]           rand_val,
  input  logic                 hit_valid,
  input  logic [SW-1:0]        hit_slot,
  input  logic                 bottom_valid,
  input  logic [SW-1:0]        bottom_slot,
  output logic                 spawn_valid,
  output logic [SW-1:0]        spawn_slot,
  output logic [9:0]           spawn_x,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [1:0]           level,
  output logic                 level_up,
  output logic [3:0]           kill_cnt,
  output logic                 miss,
  output logic [1:0]           fsm_state
);

  localparam int CW = $clog2(SPAWN_BASE + 1);
  localparam int NW = $clog2(WAVE_LEN + 1);
  localparam logic [9:0] X_LIM = 10'(MAX_X - OBS_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_SPAWN = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  // Handshake: spawn_valid, hit_valid, bottom_valid and miss/level_up are
  // single-cycle valid-only events with no ready; the receiver must take them
  // in the cycle they are high. spawn_slot/spawn_x hold between spawns.

  logic [1:0]           state;
  logic [CW-1:0]        frame_cnt;
  logic [NW-1:0]        spawned;

  logic                 free_found;
  logic [SW-1:0]        free_idx;
  logic                 hit_ok;
  logic                 bot_ok;
  logic                 spawn_go;
  logic                 wave_done;
  logic                 last_spawn;
  logic [NUM_SLOTS-1:0] rel_mask;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [1:0]           level_nxt;
  logic [CW-1:0]        period_nxt;
  logic [9:0]           x_nxt;

  assign fsm_state = state;

  function automatic logic [CW-1:0] period_of(input logic [1:0] lvl);
    return CW'(SPAWN_BASE - int'(lvl) * SPAWN_STEP);
  endfunction

  // Lowest-index free slot, taken from the registered mask only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    hit_ok = hit_valid && slot_active[hit_slot];
    // A hit on the same slot as a bottom event wins: one kill, no miss.
    bot_ok = bottom_valid && slot_active[bottom_slot] &&
             !(hit_ok && (hit_slot == bottom_slot));
    rel_mask = '0;
    if (hit_ok) rel_mask[hit_slot] = 1'b1;
    if (bot_ok) rel_mask[bottom_slot] = 1'b1;
    spawn_go = (state == S_SPAWN) && free_found;
    set_mask = '0;
    if (spawn_go) set_mask[free_idx] = 1'b1;
    wave_done  = (state == S_CLEAR) && (slot_active == '0);
    last_spawn = (spawned + NW'(1)) == NW'(WAVE_LEN);
    if (new_game) begin
      level_nxt = 2'd0;
    end else if (game_run && wave_done && (level != 2'd3)) begin
      level_nxt = level + 2'd1;
    end else begin
      level_nxt = level;
    end
    period_nxt = period_of(level_nxt);
    x_nxt = (rand_val > X_LIM) ? (rand_val - (X_LIM + 10'd1)) : rand_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      frame_cnt   <= '0;
      spawned     <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
      slot_active <= '0;
      level       <= 2'd0;
      level_up    <= 1'b0;
      kill_cnt    <= 4'd0;
      miss        <= 1'b0;
    end else begin
      spawn_valid <= 1'b0;
      level_up    <= 1'b0;
      miss        <= 1'b0;
      level       <= level_nxt;
      if (!game_run) begin
        state       <= S_IDLE;
        slot_active <= '0;
        kill_cnt    <= 4'd0;
        spawned     <= '0;
        frame_cnt   <= '0;
      end else begin
        // Spawn-set and release-clear are disjoint: spawn picks a bit that is 0.
        slot_active <= (slot_active & ~rel_mask) | set_mask;
        miss        <= bot_ok;
        if (wave_done) begin
          kill_cnt <= 4'd0;
        end else if (hit_ok && (kill_cnt != 4'hF)) begin
          kill_cnt <= kill_cnt + 4'd1;
        end
        case (state)
          S_IDLE: begin
            frame_cnt <= period_nxt;
            state     <= S_COUNT;
          end
          S_COUNT: begin
            if (refr_tick) begin
              if (frame_cnt <= CW'(1)) begin
                frame_cnt <= '0;
                state     <= S_SPAWN;
              end else begin
                frame_cnt <= frame_cnt - CW'(1);
              end
            end
          end
          S_SPAWN: begin
            if (spawn_go) begin
              spawn_valid <= 1'b1;
              spawn_slot  <= free_idx;
              spawn_x     <= x_nxt;
              frame_cnt   <= period_nxt;
              spawned     <= spawned + NW'(1);
              state       <= last_spawn ? S_CLEAR : S_COUNT;
            end
          end
          S_CLEAR: begin
            if (wave_done) begin
              level_up  <= 1'b1;
              spawned   <= '0;
              frame_cnt <= period_nxt;
              state     <= S_COUNT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obs_wave_scheduler.sv
// Bench for obs_wave_scheduler: directed game sequence with randomized x values
// and releases, checked against a slot/level/kill model kept in the bench.
module tb_obs_wave_scheduler;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;
  localparam int WAVE = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       refr_tick, game_run, new_game;
  logic [9:0] rand_val;
  logic       hit_valid, bottom_valid;
  logic [1:0] hit_slot, bottom_slot;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [3:0] slot_active;
  logic [1:0] level;
  logic       level_up;
  logic [3:0] kill_cnt;
  logic       miss;
  logic [1:0] fsm_state;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: expected {slot, x} of each spawn, pushed when stimulus is chosen.
  logic [11:0] exp_q[$];

  logic [3:0] m_act;
  int         m_kill, m_level, m_spawned;

  obs_wave_scheduler dut (
    .clk(clk), .rst(rst), .refr_tick(refr_tick), .game_run(game_run),
    .new_game(new_game), .rand_val(rand_val),
    .hit_valid(hit_valid), .hit_slot(hit_slot),
    .bottom_valid(bottom_valid), .bottom_slot(bottom_slot),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_x(spawn_x),
    .slot_active(slot_active), .level(level), .level_up(level_up),
    .kill_cnt(kill_cnt), .miss(miss), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  // Spawn is predicted purely from the game rules: period by level, x folded mod 611.
  task automatic do_spawn(input logic [9:0] r);
    int per, es, ex;
    logic [11:0] e;
    per = 60 - 8 * m_level;
    es = lowest_free();
    ex = int'(r) % 611;
    rand_val = r;
    exp_q.push_back({2'(es), 10'(ex)});
    refr_tick = 1'b1;
    repeat (per - 1) step();
    check("pre_terminal_state", 32'(fsm_state), 32'(ST_COUNT));
    step();
    refr_tick = 1'b0;
    check("spawn_early", 32'(spawn_valid), 32'd0);
    check("terminal_state", 32'(fsm_state), 32'(ST_SPAWN));
    step();
    check("spawn_valid", 32'(spawn_valid), 32'd1);
    if (spawn_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("spawn_slot", 32'(spawn_slot), 32'(e[11:10]));
      check("spawn_x", 32'(spawn_x), 32'(e[9:0]));
    end
    m_act[es] = 1'b1;
    m_spawned++;
    check("active_after_spawn", 32'(slot_active), 32'(m_act));
    check("post_spawn_state", 32'(fsm_state),
          32'((m_spawned == WAVE) ? ST_CLEAR : ST_COUNT));
    step();
    check("spawn_pulse_width", 32'(spawn_valid), 32'd0);
  endtask

  task automatic release_ev(input logic hv, input int hs, input logic bv, input int bs);
    logic h_ok, b_ok;
    h_ok = hv && m_act[hs];
    b_ok = bv && m_act[bs] && !(h_ok && hs == bs);
    hit_valid = hv;
    hit_slot = 2'(hs);
    bottom_valid = bv;
    bottom_slot = 2'(bs);
    step();
    hit_valid = 1'b0;
    bottom_valid = 1'b0;
    if (h_ok) begin
      m_act[hs] = 1'b0;
      if (m_kill < 15) m_kill++;
    end
    if (b_ok) m_act[bs] = 1'b0;
    check("rel_kill", 32'(kill_cnt), 32'(m_kill));
    check("rel_active", 32'(slot_active), 32'(m_act));
    check("rel_miss", 32'(miss), 32'(b_ok));
  endtask

  task automatic release_random();
    int cand[$];
    int s;
    for (int i = 0; i < 4; i++) if (m_act[i]) cand.push_back(i);
    if (cand.size() == 0) return;
    s = cand[$urandom_range(0, cand.size() - 1)];
    if ($urandom_range(0, 1) == 1) release_ev(1'b1, s, 1'b0, 0);
    else release_ev(1'b0, 0, 1'b1, s);
  endtask

  task automatic finish_wave();
    int guard = 0;
    while (m_act != 4'd0 && guard < 8) begin
      release_random();
      guard++;
    end
    check("clear_hold_state", 32'(fsm_state), 32'(ST_CLEAR));
    step();
    m_level = (m_level < 3) ? m_level + 1 : 3;
    m_kill = 0;
    m_spawned = 0;
    check("level_up_pulse", 32'(level_up), 32'd1);
    check("level_after_wave", 32'(level), 32'(m_level));
    check("kill_cleared", 32'(kill_cnt), 32'd0);
    check("state_after_wave", 32'(fsm_state), 32'(ST_COUNT));
    step();
    check("level_up_width", 32'(level_up), 32'd0);
  endtask

  task automatic run_wave();
    int guard = 0;
    while (m_spawned < WAVE && guard < 20) begin
      do_spawn(10'($urandom_range(0, 1023)));
      if (m_spawned < WAVE && ($countones(m_act) == 4 || $urandom_range(0, 1) == 1))
        release_random();
      guard++;
    end
    finish_wave();
  endtask

  initial begin
    logic [9:0] r;
    rst = 1'b1;
    refr_tick = 1'b0;
    game_run = 1'b0;
    new_game = 1'b0;
    rand_val = 10'd0;
    hit_valid = 1'b0;
    hit_slot = 2'd0;
    bottom_valid = 1'b0;
    bottom_slot = 2'd0;
    m_act = 4'd0;
    m_kill = 0;
    m_level = 0;
    m_spawned = 0;

    // Reset state
    #1;
    check("rst_spawn_valid", 32'(spawn_valid), 32'd0);
    check("rst_spawn_x", 32'(spawn_x), 32'd0);
    check("rst_spawn_slot", 32'(spawn_slot), 32'd0);
    check("rst_active", 32'(slot_active), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_level_up", 32'(level_up), 32'd0);
    check("rst_kill", 32'(kill_cnt), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    step();
    step();
    rst = 1'b0;

    // Basic spawn and x folding
    game_run = 1'b1;
    step();
    check("start_state", 32'(fsm_state), 32'(ST_COUNT));
    do_spawn(10'd100);
    check("basic_x", 32'(spawn_x), 32'd100);
    do_spawn(10'd700);
    check("wrap_700", 32'(spawn_x), 32'd89);
    do_spawn(10'd610);
    check("edge_610", 32'(spawn_x), 32'd610);
    do_spawn(10'd1023);
    check("wrap_1023", 32'(spawn_x), 32'd412);

    // Pool full: stall in SPAWN until a slot frees
    check("pool_full", 32'(slot_active), 32'hF);
    refr_tick = 1'b1;
    repeat (60) step();
    refr_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_state", 32'(fsm_state), 32'(ST_SPAWN));
      check("stall_no_spawn", 32'(spawn_valid), 32'd0);
      step();
    end
    r = 10'($urandom_range(0, 1023));
    rand_val = r;
    exp_q.push_back({2'd2, 10'(int'(r) % 611)});
    release_ev(1'b1, 2, 1'b0, 0);
    check("release_cycle_no_spawn", 32'(spawn_valid), 32'd0);
    check("release_cycle_state", 32'(fsm_state), 32'(ST_SPAWN));
    step();
    check("refill_valid", 32'(spawn_valid), 32'd1);
    if (spawn_valid && exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      check("refill_slot", 32'(spawn_slot), 32'(e[11:10]));
      check("refill_x", 32'(spawn_x), 32'(e[9:0]));
    end
    m_act[2] = 1'b1;
    m_spawned++;
    check("refill_active", 32'(slot_active), 32'hF);
    step();
    check("refill_width", 32'(spawn_valid), 32'd0);

    // Simultaneous releases
    release_ev(1'b1, 1, 1'b1, 1);
    release_ev(1'b1, 0, 1'b1, 3);
    step();
    check("miss_width", 32'(miss), 32'd0);
    release_ev(1'b0, 0, 1'b1, 0);

    // Waves up to level 3 and saturation
    run_wave();
    run_wave();
    run_wave();
    run_wave();
    check("level_saturated", 32'(level), 32'd3);

    // Abort mid-COUNT with slots active and kills counted
    do_spawn(10'($urandom_range(0, 1023)));
    do_spawn(10'($urandom_range(0, 1023)));
    release_ev(1'b1, 0, 1'b0, 0);
    refr_tick = 1'b1;
    repeat (10) step();
    refr_tick = 1'b0;
    game_run = 1'b0;
    step();
    m_act = 4'd0;
    m_kill = 0;
    m_spawned = 0;
    check("abort_active", 32'(slot_active), 32'd0);
    check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
    check("abort_kill", 32'(kill_cnt), 32'd0);
    check("abort_level_kept", 32'(level), 32'd3);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    m_level = 0;
    check("new_game_level", 32'(level), 32'd0);

    // Abort while in SPAWN: no spawn pulse follows
    game_run = 1'b1;
    step();
    refr_tick = 1'b1;
    repeat (60) step();
    refr_tick = 1'b0;
    check("abort_spawn_pre", 32'(fsm_state), 32'(ST_SPAWN));
    game_run = 1'b0;
    step();
    check("abort_spawn_no_pulse", 32'(spawn_valid), 32'd0);
    check("abort_spawn_state", 32'(fsm_state), 32'(ST_IDLE));

    // Restart from level 0
    game_run = 1'b1;
    step();
    do_spawn(10'($urandom_range(0, 1023)));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
